// File: rtl/timer_bank.sv
// Multi-channel counter/timer bank: CH independent N-bit channels sharing one
// prescaler tick and one load port, with terminal pulses and one-shot done flags.
module timer_bank #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4,
  parameter int unsigned PW = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [CH-1:0]         clear,
  input  logic [CH-1:0]         en,
  input  logic [CH-1:0]         up,
  input  logic [2*CH-1:0]       mode,
  input  logic [N*CH-1:0]       max,
  input  logic [PW-1:0]         prescale,
  input  logic                  load,
  input  logic [$clog2(CH)-1:0] load_ch,
  input  logic [N-1:0]          load_val,
  output logic [N*CH-1:0]       count,
  output logic [CH-1:0]         at_term,
  output logic [CH-1:0]         tc_pulse,
  output logic [CH-1:0]         done
);

  localparam int unsigned LW = $clog2(CH);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  // Lowering prescale below r_pcnt lets the counter wrap before the next tick.
  assign w_tick = (r_pcnt == prescale);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [N-1:0] r_cnt;
    logic         r_done;
    logic         r_tc;
    logic [N-1:0] w_max;
    logic [N-1:0] w_inc;
    logic [N-1:0] w_dec;
    logic [1:0]   w_mode;
    logic         w_oneshot;
    logic         w_wrap;
    logic         w_term;
    logic         w_land;
    logic         w_step;
    logic         w_load_hit;

    assign w_max      = max[N*i +: N];
    assign w_mode     = mode[2*i +: 2];
    assign w_oneshot  = (w_mode == 2'b10);
    assign w_wrap     = (w_mode == 2'b01);
    assign w_inc      = r_cnt + N'(1);
    assign w_dec      = r_cnt - N'(1);
    assign w_term     = up[i] ? (r_cnt >= w_max) : (r_cnt == '0);
    // Terminal test of the value a non-terminal step would land on.
    assign w_land     = up[i] ? (w_inc >= w_max) : (w_dec == '0);
    assign w_step     = en[i] && w_tick && !(w_oneshot && r_done);
    assign w_load_hit = load && (load_ch == LW'(i));

    // Priority: clear, load, step, hold.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
        r_tc   <= 1'b0;
      end else begin
        r_tc <= 1'b0;
        if (clear[i]) begin
          r_cnt  <= '0;
          r_done <= 1'b0;
        end else if (w_load_hit) begin
          r_cnt  <= load_val;
          r_done <= 1'b0;
        end else if (w_step) begin
          if (!w_term) begin
            r_cnt <= up[i] ? w_inc : w_dec;
            if (w_land) begin
              r_tc <= 1'b1;
              if (w_oneshot) r_done <= 1'b1;
            end
          end else if (w_wrap) begin
            r_cnt <= up[i] ? '0 : w_max;
          end else if (w_oneshot) begin
            r_done <= 1'b1;
          end
        end
      end
    end

    assign count[N*i +: N] = r_cnt;
    assign at_term[i]      = w_term;
    assign tc_pulse[i]     = r_tc;
    assign done[i]         = r_done;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_timer_bank;

  localparam int unsigned N  = 8;
  localparam int unsigned CH = 5;
  localparam int unsigned PW = 8;
  localparam int unsigned LW = $clog2(CH);

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [CH-1:0]   clear;
  logic [CH-1:0]   en;
  logic [CH-1:0]   up;
  logic [2*CH-1:0] mode;
  logic [N*CH-1:0] max;
  logic [PW-1:0]   prescale;
  logic            load;
  logic [LW-1:0]   load_ch;
  logic [N-1:0]    load_val;
  logic [N*CH-1:0] count;
  logic [CH-1:0]   at_term;
  logic [CH-1:0]   tc_pulse;
  logic [CH-1:0]   done;

  timer_bank #(.N(N), .CH(CH), .PW(PW)) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .en(en), .up(up), .mode(mode),
    .max(max), .prescale(prescale), .load(load), .load_ch(load_ch),
    .load_val(load_val), .count(count), .at_term(at_term),
    .tc_pulse(tc_pulse), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Field value -1 means "don't care".
  typedef struct {
    int    cyc;
    int    ch;
    int    cnt;
    int    tc;
    int    dn;
    int    term;
    string nm;
  } exp_t;

  exp_t q[$];

  task automatic push(input int t, input int ch, input int cnt, input int tc,
                      input int dn, input int term, input string nm);
    exp_t e;
    e.cyc = t; e.ch = ch; e.cnt = cnt; e.tc = tc; e.dn = dn; e.term = term; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input int ch, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s ch%0d @cyc%0d: got %0d expected %0d", nm, ch, cyc, act, exp_v);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      if (me.cnt  >= 0) cmp({me.nm, ".count"},    me.ch, int'(count[N*me.ch +: N]), me.cnt);
      if (me.tc   >= 0) cmp({me.nm, ".tc_pulse"}, me.ch, int'(tc_pulse[me.ch]),     me.tc);
      if (me.dn   >= 0) cmp({me.nm, ".done"},     me.ch, int'(done[me.ch]),         me.dn);
      if (me.term >= 0) cmp({me.nm, ".at_term"},  me.ch, int'(at_term[me.ch]),      me.term);
    end
  end

  task automatic quiet();
    clear = '0; en = '0; up = '1; mode = '0; max = {CH{8'h0F}};
    prescale = '0; load = 1'b0; load_ch = '0; load_val = '0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Leaves the bench at posedge+2 with nrst released; pcnt is 0 at the next edge.
  task automatic do_reset();
    nrst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      clear = CH'($urandom); en = CH'($urandom); up = CH'($urandom);
      mode = (2*CH)'($urandom); max = (N*CH)'({$urandom, $urandom});
      prescale = PW'($urandom); load = 1'($urandom);
      load_ch = LW'($urandom); load_val = N'($urandom);
    end
    quiet();
    @(posedge clk);
    #2;
    nrst = 1'b1;
  endtask

  task automatic set_ch(input int ch, input logic u, input logic [1:0] m, input logic [N-1:0] mx);
    up[ch] = u;
    mode[2*ch +: 2] = m;
    max[N*ch +: N] = mx;
  endtask

  task automatic do_load(input int ch, input logic [N-1:0] v);
    load = 1'b1; load_ch = LW'(ch); load_val = v;
  endtask

  int c0;
  int cexp;

  initial begin
    quiet();

    // Reset: everything zero, at_term = ~up.
    do_reset();
    up = 5'b01010;
    c0 = cyc;
    for (int i = 0; i < int'(CH); i++)
      push(c0 + 1, i, 0, 0, 0, up[i] ? 0 : 1, "reset");
    tick_n(2);

    // Prescale = 2: ch0 up/saturate to 5, steps every third edge.
    do_reset();
    set_ch(0, 1'b1, 2'b00, 8'd5);
    prescale = 8'd2;
    en[0] = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 20; k++) begin
      cexp = k / 3;
      if (cexp > 5) cexp = 5;
      push(c0 + k, 0, cexp, (k == 15) ? 1 : 0, 0, -1, "prescale");
    end
    tick_n(21);

    // Wrap down on ch1: 2,1,0,3,2,1,0.
    do_reset();
    set_ch(1, 1'b0, 2'b01, 8'd3);
    en[1] = 1'b1;
    do_load(1, 8'd2);
    c0 = cyc;
    push(c0 + 1, 1, 2, 0, -1, 0, "wrapdn");
    push(c0 + 2, 1, 1, 0, -1, 0, "wrapdn");
    push(c0 + 3, 1, 0, 1, -1, 1, "wrapdn");
    push(c0 + 4, 1, 3, 0, -1, 0, "wrapdn");
    push(c0 + 5, 1, 2, 0, -1, -1, "wrapdn");
    push(c0 + 6, 1, 1, 0, -1, -1, "wrapdn");
    push(c0 + 7, 1, 0, 1, -1, -1, "wrapdn");
    tick_n(1);
    load = 1'b0;
    tick_n(7);

    // One-shot on ch2: 1,2,3,4 then blocked; load 0 restarts.
    do_reset();
    set_ch(2, 1'b1, 2'b10, 8'd4);
    en[2] = 1'b1;
    do_load(2, 8'd1);
    c0 = cyc;
    push(c0 + 1, 2, 1, 0, 0, -1, "oneshot");
    push(c0 + 2, 2, 2, 0, 0, -1, "oneshot");
    push(c0 + 3, 2, 3, 0, 0, -1, "oneshot");
    push(c0 + 4, 2, 4, 1, 1, 1, "oneshot");
    push(c0 + 5, 2, 4, 0, 1, -1, "oneshot");
    push(c0 + 6, 2, 4, 0, 1, -1, "oneshot");
    push(c0 + 7, 2, 0, 0, 0, -1, "oneshot");
    push(c0 + 8, 2, 1, 0, 0, -1, "oneshot");
    push(c0 + 9, 2, 2, 0, 0, -1, "oneshot");
    tick_n(1);
    load = 1'b0;
    tick_n(5);
    do_load(2, 8'd0);
    tick_n(1);
    load = 1'b0;
    tick_n(3);

    // Priority on ch3: clear beats load, load beats a landing step, bad load_ch ignored.
    do_reset();
    set_ch(3, 1'b1, 2'b00, 8'd8);
    clear[3] = 1'b1;
    do_load(3, 8'd7);
    c0 = cyc;
    push(c0 + 1, 3, 0, 0, 0, -1, "clr_vs_load");
    push(c0 + 2, 3, 7, 0, 0, -1, "load");
    push(c0 + 3, 3, 7, 0, 0, -1, "load_vs_step");
    for (int i = 0; i < int'(CH); i++)
      push(c0 + 4, i, (i == 3) ? 7 : 0, 0, 0, -1, "bad_load_ch");
    push(c0 + 5, 3, 8, 1, 0, 1, "land_after_load");
    tick_n(1);
    clear[3] = 1'b0;
    tick_n(1);
    en[3] = 1'b1;
    tick_n(1);
    en[3] = 1'b0;
    do_load(CH, 8'h55);
    tick_n(1);
    load = 1'b0;
    en[3] = 1'b1;
    tick_n(1);
    en[3] = 1'b0;
    tick_n(1);

    // Over-limit load on ch4 (wrap up), then asynchronous reset mid-count.
    do_reset();
    set_ch(4, 1'b1, 2'b01, 8'd5);
    do_load(4, 8'd9);
    c0 = cyc;
    push(c0 + 1, 4, 9, 0, 0, 1, "overlimit");
    push(c0 + 2, 4, 0, 0, 0, -1, "overlimit_wrap");
    push(c0 + 3, 4, 1, 0, 0, -1, "overlimit");
    push(c0 + 4, 4, 2, 0, 0, -1, "overlimit");
    tick_n(1);
    load = 1'b0;
    en[4] = 1'b1;
    tick_n(3);
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    cmp("async_reset.count", 4, int'(count[N*4 +: N]), 0);
    cmp("async_reset.tc_pulse", 4, int'(tc_pulse[4]), 0);
    tick_n(2);
    nrst = 1'b1;

    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel, parametrised counter/timer bank replacing single-channel counter instances wherever several related counts share one clock domain. It has CH independent channels of width N, each with a direction, a mode (saturate, wrap or one-shot) and its own limit. A shared prescaler gates all channels, and a single load port writes one channel per cycle. Terminal-count pulses and sticky done flags feed the control FSMs downstream.

## Interface
- N, 8: channel counter width, N >= 2
- CH, 4: channel count, CH >= 2
- PW, 8: prescaler width
- clk  in  1  clock; all state updates on the rising edge
- nrst  in  1  reset, asynchronous, active-low
- clear  in  CH  per-channel synchronous clear
- en  in  CH  per-channel step enable
- up  in  CH  direction: 1 = count up, 0 = count down
- mode  in  2*CH  channel i in bits [2i+1:2i]: 00 saturate, 01 wrap, 10 one-shot, 11 treated as 00
- max  in  N*CH  channel i limit in bits [N*i+N-1:N*i]
- prescale  in  PW  step tick every prescale+1 cycles
- load  in  1  load strobe
- load_ch  in  $clog2(CH)  target channel of the load
- load_val  in  N  value to load
- count  out  N*CH  channel counts, packed like max
- at_term  out  CH  combinational terminal flag
- tc_pulse  out  CH  registered one-cycle terminal-count pulse
- done  out  CH  sticky one-shot completion flag

## Operation
- Prescaler: a free-running counter pcnt. tick = (pcnt == prescale), and pcnt returns to 0 on tick, otherwise increments. prescale = 0 gives a tick every cycle. If prescale is lowered below pcnt, pcnt counts up and wraps modulo 2^PW before the next tick.
- Terminal condition: at_term[i] = (count >= max) when up = 1, and (count == 0) when up = 0.
- Step: a step occurs when en[i] && tick, and not (mode == one-shot && done[i]).
- Per-channel priority, highest first: clear, then load (load && load_ch == i), then step, then hold.
- Step with at_term = 0: count increments (up) or decrements (down).
- Step with at_term = 1:
  - saturate: count holds.
  - wrap: count goes to 0 when counting up, or to max when counting down.
  - one-shot: count holds and done is set.
- One-shot also sets done on the step that lands on the terminal value. Further steps are blocked until a clear or a load.
- Landing: a step moves count from a non-terminal value to a terminal value. tc_pulse[i] = 1 on the cycle after a landing, in every mode. There is no pulse on a wrap jump, a hold at terminal, a load or a clear.
- Load writes load_val unmodified, including values > max, and clears done. load_ch >= CH is ignored.
- Clear sets count to 0 and done to 0.
- max = 0 in wrap mode counting up: count stays at 0 and no pulse is generated.
- Changing up, mode or max mid-count takes effect on the next step. No state is reset.
- Channels are fully independent apart from the shared tick and load port.

## Timing
- Reset values: count 0, done 0, tc_pulse 0, pcnt 0. at_term follows count, so it reads 1 for down-counting channels after reset.
- nrst asserted mid-operation resets all state immediately, without waiting for clk.
- count, done and tc_pulse all update on the same edge as the step that causes them. Step-to-count latency is 1 cycle.
- tc_pulse is high for exactly one cycle per landing. Back-to-back landings (for example a reload followed by an immediate tick) give back-to-back pulses.
- clear and load take effect at the next edge regardless of en or tick.
- clear and load on the same channel in the same cycle: clear wins, and the loaded value is discarded.
- Load and step on the same channel in the same cycle: the load wins and the step is lost.

## Test plan
- Reset: hold nrst = 0 with random inputs, then release. Required: all counts 0, tc_pulse 0, done 0; at_term = ~up.
- Prescale: prescale = 2, ch0 up, saturate, max = 5, en = 1. Required: count steps every 3 cycles to 5; one tc_pulse on the cycle count becomes 5; count then holds at 5.
- Wrap down: ch1 down, wrap, max = 3, prescale = 0, load 2. Required: sequence 2,1,0,3,2,1,0; tc_pulse after each arrival at 0; no pulse on the 0 -> 3 jump.
- One-shot: ch2 up, max = 4, load 1. Required: 1,2,3,4; done set with count = 4; steps ignored afterwards; a load of 0 clears done and counting resumes.
- Priority: on ch3, same-cycle clear + load(7) gives count 0. Same-cycle load(7) + step gives count 7 with no tc_pulse. load_ch = CH gives no change on any channel.
- Over-limit: load 9 with max = 5, up, wrap. Required: at_term = 1; the next step gives 0. Assert nrst mid-count: count is 0 immediately.
